// File: rtl/ripple_count_monitor.sv
// Clean-count monitor for a 3-bit ripple mod-8 counter: resynchronises the raw value,
// commits only values seen stable for two sampled cycles, and reports wraps, matches and sequence errors.
module ripple_count_monitor #(
    parameter int WRAP_W    = 8,
    parameter bit CHECK_SEQ = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cnt_in,
    input  logic [2:0]        match_val,
    input  logic              clr_wraps,
    output logic [2:0]        count_out,
    output logic              count_valid,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              wrap_ovf,
    output logic              seq_err
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t            state_reg;
    logic [2:0]        s1_reg;
    logic [2:0]        s2_reg;
    logic [2:0]        s3_reg;
    logic [2:0]        fill_reg;
    logic [2:0]        count_reg;
    logic              valid_reg;
    logic              wrap_pulse_reg;
    logic              match_pulse_reg;
    logic [WRAP_W-1:0] wrap_count_reg;
    logic              wrap_ovf_reg;
    logic              seq_err_reg;

    logic commit;
    logic is_wrap;
    logic is_match;
    logic is_skip;
    logic wraps_full;

    // fill_reg[2] marks that s3 holds a real post-reset sample, so the zeros left
    // in the pipe by reset are never mistaken for a stable counter value.
    always_comb begin
        commit     = fill_reg[2] && (s2_reg == s3_reg) &&
                     ((state_reg == ST_INIT) || (s2_reg != count_reg));
        is_wrap    = commit && (state_reg == ST_TRACK) &&
                     (count_reg == 3'd7) && (s2_reg == 3'd0);
        is_match   = commit && (s2_reg == match_val);
        is_skip    = commit && (state_reg == ST_TRACK) &&
                     (s2_reg != (count_reg + 3'd1));
        wraps_full = &wrap_count_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_INIT;
            s1_reg          <= '0;
            s2_reg          <= '0;
            s3_reg          <= '0;
            fill_reg        <= '0;
            count_reg       <= '0;
            valid_reg       <= 1'b0;
            wrap_pulse_reg  <= 1'b0;
            match_pulse_reg <= 1'b0;
            wrap_count_reg  <= '0;
            wrap_ovf_reg    <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            s1_reg   <= cnt_in;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            fill_reg <= {fill_reg[1:0], 1'b1};

            wrap_pulse_reg  <= is_wrap;
            match_pulse_reg <= is_match;

            if (commit) begin
                count_reg <= s2_reg;
            end

            case (state_reg)
                ST_INIT: begin
                    if (commit) begin
                        state_reg <= ST_TRACK;
                        valid_reg <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (CHECK_SEQ && is_skip) begin
                        seq_err_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase

            // A clear coinciding with a wrap leaves that wrap counted.
            if (clr_wraps) begin
                wrap_count_reg <= is_wrap ? WRAP_W'(1) : '0;
                wrap_ovf_reg   <= 1'b0;
            end else if (is_wrap) begin
                if (wraps_full) begin
                    wrap_ovf_reg <= 1'b1;
                end else begin
                    wrap_count_reg <= wrap_count_reg + WRAP_W'(1);
                end
            end
        end
    end

    assign count_out   = count_reg;
    assign count_valid = valid_reg;
    assign wrap_pulse  = wrap_pulse_reg;
    assign match_pulse = match_pulse_reg;
    assign wrap_count  = wrap_count_reg;
    assign wrap_ovf    = wrap_ovf_reg;
    assign seq_err     = seq_err_reg;

endmodule
